// File: rtl/jt12_seq_pkg.sv
// Shared constants, slot-group encoding and modulation select tables
// for the high-precision operator slot sequencer.
package jt12_seq_pkg;

    localparam int SLOTS     = 24;
    localparam int GROUP_LEN = 6;

    // Slot groups in the order the step counter visits them
    typedef enum logic [1:0] {
        GRP_S1 = 2'd0,
        GRP_S3 = 2'd1,
        GRP_S2 = 2'd2,
        GRP_S4 = 2'd3
    } grp_e;

    typedef struct packed {
        logic xuse_prevprev1;
        logic xuse_prev2;
        logic xuse_internal;
        logic yuse_prev1;
        logic yuse_prev2;
        logic yuse_internal;
    } sel_t;

    // Select tables indexed by algorithm 0..7.
    // Bit order: {xprevprev1, xprev2, xinternal, yprev1, yprev2, yinternal}
    localparam sel_t SEL_S1 [8] = '{
        6'b100100, 6'b100100, 6'b100100, 6'b100100,
        6'b100100, 6'b100100, 6'b100100, 6'b100100
    };
    localparam sel_t SEL_S3 [8] = '{
        6'b010000, 6'b000000, 6'b000000, 6'b010000,
        6'b010000, 6'b010000, 6'b010000, 6'b000000
    };
    localparam sel_t SEL_S2 [8] = '{
        6'b001000, 6'b010001, 6'b001000, 6'b000000,
        6'b000000, 6'b010000, 6'b000000, 6'b000000
    };
    localparam sel_t SEL_S4 [8] = '{
        6'b000100, 6'b000100, 6'b010100, 6'b001100,
        6'b000100, 6'b010000, 6'b000000, 6'b000000
    };

    // Slot group of a step 0..23
    function automatic grp_e step_grp(input logic [4:0] s);
        if (s < 5'd6)
            return GRP_S1;
        else if (s < 5'd12)
            return GRP_S3;
        else if (s < 5'd18)
            return GRP_S2;
        else
            return GRP_S4;
    endfunction

    // Channel of a step 0..23 (step mod 6)
    function automatic logic [2:0] step_ch(input logic [4:0] s);
        if (s < 5'd6)
            return s[2:0];
        else if (s < 5'd12)
            return 3'(s - 5'd6);
        else if (s < 5'd18)
            return 3'(s - 5'd12);
        else
            return 3'(s - 5'd18);
    endfunction

endpackage

// File: rtl/jt12_op_algsel.sv
// Combinational mapping of (slot group, algorithm) to the six
// modulation source select bits.
module jt12_op_algsel
    import jt12_seq_pkg::*;
(
    input  grp_e       grp,
    input  logic [2:0] alg,
    output sel_t       sel
);

    // Table lookup for the slot group being entered
    always_comb begin
        sel = '0;
        case (grp)
            GRP_S1:  sel = SEL_S1[alg];
            GRP_S3:  sel = SEL_S3[alg];
            GRP_S2:  sel = SEL_S2[alg];
            GRP_S4:  sel = SEL_S4[alg];
            default: sel = '0;
        endcase
    end

endmodule

// File: rtl/jt12_op_seq_hd.sv
// Slot sequencer and modulation-routing controller for the
// high-precision operator pipeline: step counter, per-channel
// algorithm/feedback register file, registered slot decode and
// frame-synchronised FMO mode latch.
module jt12_op_seq_hd
    import jt12_seq_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       wr,
    input  logic [2:0] wr_ch,
    input  logic [2:0] wr_alg,
    input  logic [2:0] wr_fb,
    input  logic       fmo_gain_req,
    input  logic       fmo_exprom_req,
    input  logic       fmo_extra_req,
    input  logic [1:0] fmo_sinelut_req,
    output logic       s1_enters,
    output logic       s2_enters,
    output logic       s3_enters,
    output logic       s4_enters,
    output logic       zero,
    output logic [2:0] ch,
    output logic       xuse_prevprev1,
    output logic       xuse_prev2,
    output logic       xuse_internal,
    output logic       yuse_prev1,
    output logic       yuse_prev2,
    output logic       yuse_internal,
    output logic [2:0] fb_II,
    output logic       fmo_gain,
    output logic       fmo_exprom,
    output logic       fmo_extra,
    output logic [1:0] fmo_sinelut
);

    localparam logic [4:0] LAST_STEP = 5'(SLOTS - 1);
    localparam logic [2:0] CH_LIM    = 3'(NUM_CH);

    // nstep is the step the next clk_en edge will present, so reset
    // to 0 makes the first clk_en after reset present step 0.
    logic [4:0] nstep;
    logic [2:0] alg_q [NUM_CH];
    logic [2:0] fb_q  [NUM_CH];

    grp_e       ngrp;
    logic [2:0] nch;
    logic [2:0] rd_alg;
    sel_t       sel_d;

    // Decode of the step being entered; register file read is the
    // pre-edge content since writes land on the same edge.
    always_comb begin
        ngrp   = step_grp(nstep);
        nch    = step_ch(nstep);
        rd_alg = alg_q[nch];
    end

    jt12_op_algsel u_algsel (
        .grp (ngrp),
        .alg (rd_alg),
        .sel (sel_d)
    );

    // Step counter, wraps after the last slot of the frame
    always_ff @(posedge clk) begin
        if (rst)
            nstep <= '0;
        else if (clk_en)
            nstep <= (nstep == LAST_STEP) ? '0 : nstep + 5'd1;
    end

    // Register file: writes on any edge, out-of-range channels ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                alg_q[i] <= '0;
                fb_q[i]  <= '0;
            end
        end else if (wr && (wr_ch < CH_LIM)) begin
            alg_q[wr_ch] <= wr_alg;
            fb_q[wr_ch]  <= wr_fb;
        end
    end

    // Registered slot outputs; fb_II reads the channel currently
    // presented so it lags ch by one step and sees writes made on
    // the edge that entered that step.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_enters      <= 1'b0;
            s2_enters      <= 1'b0;
            s3_enters      <= 1'b0;
            s4_enters      <= 1'b0;
            zero           <= 1'b0;
            ch             <= '0;
            xuse_prevprev1 <= 1'b0;
            xuse_prev2     <= 1'b0;
            xuse_internal  <= 1'b0;
            yuse_prev1     <= 1'b0;
            yuse_prev2     <= 1'b0;
            yuse_internal  <= 1'b0;
            fb_II          <= '0;
        end else if (clk_en) begin
            s1_enters      <= (ngrp == GRP_S1);
            s2_enters      <= (ngrp == GRP_S2);
            s3_enters      <= (ngrp == GRP_S3);
            s4_enters      <= (ngrp == GRP_S4);
            zero           <= (nstep == '0);
            ch             <= nch;
            xuse_prevprev1 <= sel_d.xuse_prevprev1;
            xuse_prev2     <= sel_d.xuse_prev2;
            xuse_internal  <= sel_d.xuse_internal;
            yuse_prev1     <= sel_d.yuse_prev1;
            yuse_prev2     <= sel_d.yuse_prev2;
            yuse_internal  <= sel_d.yuse_internal;
            fb_II          <= fb_q[ch];
        end
    end

    // FMO mode bits only change on the edge that presents step 0
    always_ff @(posedge clk) begin
        if (rst) begin
            fmo_gain    <= 1'b0;
            fmo_exprom  <= 1'b0;
            fmo_extra   <= 1'b0;
            fmo_sinelut <= '0;
        end else if (clk_en && (nstep == '0)) begin
            fmo_gain    <= fmo_gain_req;
            fmo_exprom  <= fmo_exprom_req;
            fmo_extra   <= fmo_extra_req;
            fmo_sinelut <= fmo_sinelut_req;
        end
    end

endmodule

// File: doc/jt12_op_seq_hd.md
# jt12_op_seq_hd

Slot sequencer and modulation-routing controller for the high-precision (FM Overdrive) operator pipeline. It steps through the 24 operator slots of a frame (6 channels × 4 operators) and issues the per-slot control the operator datapath consumes: slot-enter strobes, frame-start marker, FM source selects and the channel feedback level. It also holds the per-channel algorithm/feedback register file and frame-synchronises the FMO mode controls, so a mode change never splits a frame.

## Interface
- NUM_CH, 6: channels per frame; only 6 is supported.
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, and reset is synchronous and active-high.
- clk_en  in  1  pipeline advance strobe; all slot state moves only when high.
- wr  in  1  register-file write strobe, sampled on any clk edge, regardless of clk_en.
- wr_ch  in  3  target channel 0..5; values 6 and 7 are ignored.
- wr_alg  in  3  algorithm 0..7.
- wr_fb  in  3  feedback level 0..7.
- fmo_gain_req, fmo_exprom_req, fmo_extra_req  in  1 each  requested FMO mode bits.
- fmo_sinelut_req  in  2  requested sine LUT mode.
- s1_enters, s2_enters, s3_enters, s4_enters  out  1 each  one-hot slot strobe.
- zero  out  1  high on the first slot of the frame.
- ch  out  3  channel of the current slot.
- xuse_prevprev1, xuse_prev2, xuse_internal  out  1 each  X modulation source select.
- yuse_prev1, yuse_prev2, yuse_internal  out  1 each  Y modulation source select.
- fb_II  out  3  feedback level, aligned to datapath stage II.
- fmo_gain, fmo_exprom, fmo_extra  out  1 each  frame-latched FMO mode bits.
- fmo_sinelut  out  2  frame-latched sine LUT mode.

## Operation
- The step counter runs 0..23 and increments on each clk_en. After 23 it wraps to 0.
- Slot group: steps 0-5 are S1, 6-11 are S3, 12-17 are S2, 18-23 are S4. ch = step mod 6.
- Operator roles: op1=S1, op2=S3, op3=S2, op4=S4.
- Register file: alg[6] and fb[6], 3 bits each.
  - A write updates alg[wr_ch] and fb[wr_ch] together.
  - A write and a read of the same channel on the same edge: the read returns the old value.
- Select table. Any select not listed is 0.
  - S1, all algorithms: xuse_prevprev1 = 1, yuse_prev1 = 1 (feedback path).
  - S3: xuse_prev2 = 1 for alg 0, 3, 4, 5, 6.
  - S2:
    - xuse_internal = 1 for alg 0, 2.
    - xuse_prev2 = 1 for alg 1, 5.
    - yuse_internal = 1 for alg 1.
  - S4:
    - yuse_prev1 = 1 for alg 0, 1, 2, 3, 4.
    - xuse_prev2 = 1 for alg 2, 5.
    - xuse_internal = 1 for alg 3.
- fb_II: holds fb[ch] of the previous step, valid for every slot. The datapath uses it only on the step after s1_enters.
- FMO latch: the *_req inputs copy to the fmo_* outputs on the same clk_en edge that presents step 0.

## Timing
- Reset: the counter is set so the first clk_en after reset presents step 0. Reset values:
  - all outputs 0;
  - alg[] and fb[] all 0;
  - the fmo_* outputs 0.
- All outputs are registered.
  - On each clk_en edge they take the decode of the step being entered, using the register-file contents from before that edge.
  - With clk_en low, all outputs hold.
- zero and s1_enters with ch=0 are asserted together for exactly one clk_en period per 24.
- fb_II lags ch by one clk_en step.
- Writes take effect for the next read of that channel. A write during step k to channel ch(k+1) is visible at step k+2, never at step k+1.
- rst asserted mid-frame: the counter and all outputs return to their reset state on that edge, and the frame restarts. rst takes priority over a simultaneous wr and over clk_en.
- FMO request changes mid-frame are invisible until the next step-0 edge. Only the last value before that edge is taken.

## Structure
- Shared package jt12_seq_pkg holds:
  - the constants SLOTS=24 and GROUP_LEN=6;
  - the group-order encoding;
  - the 8-entry select table, as 6-bit constants per slot group.
- One sub-module, jt12_op_algsel: combinational mapping of (slot group, alg) to the six select bits.
- The top holds the counter, register file, output registers and FMO latch.

## Test plan
- Reset, then 48 clk_en pulses -> zero at pulses 1 and 25 only; s1_enters on pulses 1-6; s3_enters on 7-12; s2_enters on 13-18; s4_enters on 19-24; ch cycles 0..5 within each group.
- Write ch2 alg=3 fb=5, then run a frame -> at step 2: xuse_prevprev1 = yuse_prev1 = 1; at step 3: fb_II = 5; at step 20 (S4): xuse_internal = 1 and yuse_prev1 = 1.
- Sweep all 8 algorithms on ch0 -> every slot's selects match the table, with no two X selects or two Y selects high together.
- Toggle fmo_gain_req at step 10 -> fmo_gain changes only at the next step 0.
- Write ch1 at step 0 (wr coincident with clk_en) -> step 1 shows the old alg, and the next frame shows the new one. A write with wr_ch = 7 leaves all channels unchanged.
- Assert rst at step 14 with wr active -> outputs go to 0, no write occurs, and the next clk_en presents step 0.
